// File: rtl/i2c_slave_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slave_pkg
// Shared definitions for the I2C target:
//   - state_t     : protocol FSM states
//   - I2C_BYTE_W  : bits per I2C byte
//   - I2C_ACK / I2C_NACK : value of SDA during the acknowledge bit
// ---------------------------------------------------------------------------
package i2c_slave_pkg;

  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings the raw SCL/SDA pad signals into the clock domain and decodes bus
// events as single-cycle pulses.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_scl, i_sda          : raw pad inputs (asynchronous)
//   o_scl_rise/o_scl_fall : one-cycle pulses on synchronized SCL edges
//   o_start_det           : SDA fell while SCL high
//   o_stop_det            : SDA rose while SCL high
//   o_sda                 : synchronized SDA level
// ---------------------------------------------------------------------------
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda
);

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  // Flops reset to 1 so an idle bus produces no spurious events after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  assign o_scl_rise  = r_scl_sync & ~r_scl_prev;
  assign o_scl_fall  = ~r_scl_sync & r_scl_prev;
  // SCL must be high on both samples so an SDA change at an SCL edge is
  // never mistaken for START/STOP.
  assign o_start_det = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign o_stop_det  = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
  assign o_sda       = r_sda_sync;

endmodule

// File: rtl/i2c_slave_target.sv
// ---------------------------------------------------------------------------
// i2c_slave_target
// I2C target with a byte-wide register file and auto-incrementing pointer.
// A write transfer loads the pointer from the first data byte and then writes
// successive registers; a read transfer returns registers from the pointer.
// Ports:
//   wb_clk_i   : system clock (>= 10x SCL)
//   arst_ni    : asynchronous active-low reset
//   scl_i      : raw SCL pad input
//   sda_i      : raw SDA pad input
//   sda_oe_o   : 1 = pull SDA low
//   busy_o     : addressed transfer in progress
//   wr_stb_o   : one-cycle pulse per committed byte
//   wr_ptr_o   : register index written (valid with wr_stb_o)
//   wr_data_o  : byte written (valid with wr_stb_o)
// ---------------------------------------------------------------------------
module i2c_slave_target
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        arst_ni,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe_o,
  output logic                        busy_o,
  output logic                        wr_stb_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_ptr_o,
  output logic [7:0]                  wr_data_o
);

  localparam int         PTR_W    = $clog2(NUM_REGS);
  localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_W - 1);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_bus_sync u_sync (
    .i_clk       (wb_clk_i),
    .i_rst_n     (arst_ni),
    .i_scl       (scl_i),
    .i_sda       (sda_i),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop),
    .o_sda       (w_sda)
  );

  state_t           r_state, w_state_next;
  logic [2:0]       r_bit_cnt, w_bit_cnt_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [PTR_W-1:0] r_ptr, w_ptr_next;
  logic             r_sda_oe, w_sda_oe_next;
  logic             r_busy, w_busy_next;
  logic             r_wr_stb, w_wr_stb_next;
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [7:0]       r_wr_data, w_wr_data_next;
  // ACK states span two SCL falls: first drives the ACK/prepares, second
  // releases. In RDATA_ACK it remembers that the master ACKed.
  logic             r_ack_phase, w_ack_phase_next;
  logic             w_we;
  logic [7:0]       w_rx_byte;
  logic [7:0]       w_rd_byte;

  logic [7:0] r_mem [NUM_REGS];

  assign w_rx_byte = {r_shift[6:0], w_sda};
  assign w_rd_byte = r_mem[r_ptr];

  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_ptr_next       = r_ptr;
    w_sda_oe_next    = r_sda_oe;
    w_busy_next      = r_busy;
    w_wr_stb_next    = 1'b0;
    w_wr_ptr_next    = r_wr_ptr;
    w_wr_data_next   = r_wr_data;
    w_ack_phase_next = r_ack_phase;
    w_we             = 1'b0;

    if (w_stop) begin
      w_state_next     = ST_IDLE;
      w_sda_oe_next    = 1'b0;
      w_busy_next      = 1'b0;
      w_ack_phase_next = 1'b0;
    end else if (w_start) begin
      w_state_next     = ST_ADDR;
      w_bit_cnt_next   = '0;
      w_sda_oe_next    = 1'b0;
      w_ack_phase_next = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: ;

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_next   = w_rx_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) begin
              if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                w_busy_next      = 1'b1;
                w_state_next     = ST_ADDR_ACK;
                w_ack_phase_next = 1'b0;
              end else begin
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_oe_next    = ~I2C_ACK;
              w_ack_phase_next = 1'b1;
            end else begin
              w_ack_phase_next = 1'b0;
              w_bit_cnt_next   = '0;
              if (r_shift[0]) begin
                // Read: first bit goes out on the same fall that ends the ACK.
                w_state_next  = ST_RDATA;
                w_shift_next  = w_rd_byte;
                w_sda_oe_next = ~w_rd_byte[7];
              end else begin
                w_state_next  = ST_PTR;
                w_sda_oe_next = 1'b0;
              end
            end
          end
        end

        ST_PTR: begin
          if (w_scl_rise) begin
            w_shift_next   = w_rx_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_ptr_next       = w_rx_byte[PTR_W-1:0];
              w_state_next     = ST_PTR_ACK;
              w_ack_phase_next = 1'b0;
            end
          end
        end

        ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_next   = w_rx_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_we             = 1'b1;
              w_wr_stb_next    = 1'b1;
              w_wr_ptr_next    = r_ptr;
              w_wr_data_next   = w_rx_byte;
              w_ptr_next       = r_ptr + 1'b1;
              w_state_next     = ST_WDATA_ACK;
              w_ack_phase_next = 1'b0;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_oe_next    = ~I2C_ACK;
              w_ack_phase_next = 1'b1;
            end else begin
              w_ack_phase_next = 1'b0;
              w_sda_oe_next    = 1'b0;
              w_bit_cnt_next   = '0;
              w_state_next     = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == LAST_BIT) begin
              w_sda_oe_next    = 1'b0;
              w_state_next     = ST_RDATA_ACK;
              w_ack_phase_next = 1'b0;
            end else begin
              // Rotate so the next bit to send sits in the MSB.
              w_shift_next   = {r_shift[6:0], r_shift[7]};
              w_sda_oe_next  = ~r_shift[6];
              w_bit_cnt_next = r_bit_cnt + 3'd1;
            end
          end
        end

        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_ptr_next = r_ptr + 1'b1;
            if (w_sda == I2C_NACK) begin
              w_state_next  = ST_IDLE;
              w_sda_oe_next = 1'b0;
              w_busy_next   = 1'b0;
            end else begin
              w_ack_phase_next = 1'b1;
            end
          end else if (w_scl_fall && r_ack_phase) begin
            // Pointer already advanced on the ACK rise.
            w_ack_phase_next = 1'b0;
            w_shift_next     = w_rd_byte;
            w_sda_oe_next    = ~w_rd_byte[7];
            w_bit_cnt_next   = '0;
            w_state_next     = ST_RDATA;
          end
        end

        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_ptr    <= '0;
      r_wr_data   <= '0;
      r_ack_phase <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_ptr       <= w_ptr_next;
      r_sda_oe    <= w_sda_oe_next;
      r_busy      <= w_busy_next;
      r_wr_stb    <= w_wr_stb_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_wr_data   <= w_wr_data_next;
      r_ack_phase <= w_ack_phase_next;
      if (w_we) r_mem[r_ptr] <= w_rx_byte;
    end
  end

  assign sda_oe_o  = r_sda_oe;
  assign busy_o    = r_busy;
  assign wr_stb_o  = r_wr_stb;
  assign wr_ptr_o  = r_wr_ptr;
  assign wr_data_o = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_target
// Directed bit-banged I2C master driving i2c_slave_target. SDA is modelled
// as a wired-AND of the master drive and the target's open-drain pull.
// ---------------------------------------------------------------------------
module tb_i2c_slave_target;

  localparam int Q = 10; // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       arst_n;
  logic       scl_m, sda_m;
  wire        sda_line;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_ptr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_target #(.SLAVE_ADDR(7'h50), .NUM_REGS(16)) dut (
    .wb_clk_i  (clk),
    .arst_ni   (arst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe_o  (sda_oe),
    .busy_o    (busy),
    .wr_stb_o  (wr_stb),
    .wr_ptr_o  (wr_ptr),
    .wr_data_o (wr_data)
  );

  int          total = 0;
  int          bad   = 0;
  logic [11:0] wlog[$];
  logic        oe_seen = 1'b0, busy_seen = 1'b0, stb_prev = 1'b0, stb_long = 1'b0;

  always @(negedge clk) begin
    if (wr_stb) wlog.push_back({wr_ptr, wr_data});
    if (wr_stb && stb_prev) stb_long = 1'b1;
    stb_prev = wr_stb;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [11:0] exp);
    chk(tag, (idx < wlog.size()) ? {20'd0, wlog[idx]} : 32'hDEAD, {20'd0, exp});
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // Works both from idle (SCL high) and as repeated START (SCL low).
  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
    $display("write byte %02h ack=%0b", d, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(ack);
    $display("read byte %02h master_ack=%0b", d, ack);
  endtask

  logic       a;
  logic [7:0] d;

  initial begin
    arst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_wptr", wr_ptr, 0);
    chk("rst_wdata", wr_data, 0);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: write ptr 3, data A5 5A
    wlog.delete();
    i2c_start();
    write_byte(8'hA0, a); chk("t1_addr_ack", a, 0);
    chk("t1_busy", busy, 1);
    write_byte(8'h03, a); chk("t1_ptr_ack", a, 0);
    write_byte(8'hA5, a); chk("t1_d0_ack", a, 0);
    write_byte(8'h5A, a); chk("t1_d1_ack", a, 0);
    i2c_stop(); wait_q();
    chk("t1_busy_after_stop", busy, 0);
    chk("t1_nwr", wlog.size(), 2);
    chk_log("t1_wr0", 0, {4'h3, 8'hA5});
    chk_log("t1_wr1", 1, {4'h4, 8'h5A});

    // 2: set ptr 3, repeated START, read 2 bytes
    wlog.delete();
    i2c_start();
    write_byte(8'hA0, a); chk("t2_addr_ack", a, 0);
    write_byte(8'h03, a); chk("t2_ptr_ack", a, 0);
    i2c_start();
    write_byte(8'hA1, a); chk("t2_raddr_ack", a, 0);
    read_byte(d, 1'b0); chk("t2_rd0", d, 8'hA5);
    chk("t2_busy_mid", busy, 1);
    read_byte(d, 1'b1); chk("t2_rd1", d, 8'h5A);
    chk("t2_busy_after_nack", busy, 0);
    i2c_stop(); wait_q();
    chk("t2_nwr", wlog.size(), 0);

    // 3: wrong address, whole write ignored
    wlog.delete(); oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, a); chk("t3_addr_nack", a, 1);
    write_byte(8'h10, a); chk("t3_d0_nack", a, 1);
    write_byte(8'h33, a); chk("t3_d1_nack", a, 1);
    i2c_stop(); wait_q();
    chk("t3_oe_seen", oe_seen, 0);
    chk("t3_busy_seen", busy_seen, 0);
    chk("t3_nwr", wlog.size(), 0);

    // 4: pointer wrap 15 -> 0 on write and read
    wlog.delete();
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h0F, a);
    write_byte(8'h11, a); chk("t4_d0_ack", a, 0);
    write_byte(8'h22, a); chk("t4_d1_ack", a, 0);
    i2c_stop(); wait_q();
    chk("t4_nwr", wlog.size(), 2);
    chk_log("t4_wr0", 0, {4'hF, 8'h11});
    chk_log("t4_wr1", 1, {4'h0, 8'h22});
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h0F, a);
    i2c_start();
    write_byte(8'hA1, a); chk("t4_raddr_ack", a, 0);
    read_byte(d, 1'b0); chk("t4_rd0", d, 8'h11);
    read_byte(d, 1'b1); chk("t4_rd1", d, 8'h22);
    i2c_stop(); wait_q();

    // 5: STOP mid-byte discards the byte and leaves the pointer alone
    wlog.delete();
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h08, a); write_byte(8'h88, a);
    i2c_stop(); wait_q();
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h06, a); write_byte(8'h66, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop(); wait_q();
    chk("t5_busy", busy, 0);
    chk("t5_nwr", wlog.size(), 2);
    chk_log("t5_wr0", 0, {4'h8, 8'h88});
    chk_log("t5_wr1", 1, {4'h6, 8'h66});
    i2c_start();
    write_byte(8'hA1, a); chk("t5_raddr_ack", a, 0);
    read_byte(d, 1'b0); chk("t5_rd_ptr7", d, 8'h00);
    read_byte(d, 1'b1); chk("t5_rd_ptr8", d, 8'h88);
    i2c_stop(); wait_q();

    // 6: async reset while driving a 0 bit in RDATA
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h04, a);
    i2c_start();
    write_byte(8'hA1, a); chk("t6_raddr_ack", a, 0);
    chk("t6_oe_before", sda_oe, 1);
    arst_n = 1'b0;
    #1;
    chk("t6_oe_async", sda_oe, 0);
    chk("t6_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    i2c_stop(); wait_q();
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h03, a);
    i2c_start();
    write_byte(8'hA1, a); chk("t6_raddr2_ack", a, 0);
    read_byte(d, 1'b0); chk("t6_rd3", d, 8'h00);
    read_byte(d, 1'b1); chk("t6_rd4", d, 8'h00);
    i2c_stop(); wait_q();

    chk("stb_one_cycle", stb_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

RTL I2C target (slave) that answers the I2C master exercised by the I2C/Wishbone environment, serving as its bus-side responder and DUT companion. It oversamples SCL/SDA on the system clock and detects START, STOP and repeated START. It matches a 7-bit address and ACKs it. It holds a byte-wide register file addressed by an auto-incrementing pointer: write transfers load the pointer, then data, and read transfers return data from the current pointer.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to
- NUM_REGS, 16, register file depth; power of two, 2..256
- wb_clk_i  in  1  system clock; must be at least 10x the SCL frequency
- arst_ni  in  1  asynchronous, active-low reset
- scl_i  in  1  raw SCL from the pad (asynchronous)
- sda_i  in  1  raw SDA from the pad (asynchronous)
- sda_oe_o  out  1  1 = pull SDA low (open drain); 0 = release
- busy_o  out  1  high from an address-matched START until STOP, NACK or mismatch
- wr_stb_o  out  1  one-cycle pulse when a data byte is committed to the register file
- wr_ptr_o  out  $clog2(NUM_REGS)  register index written; valid with wr_stb_o
- wr_data_o  out  8  byte written; valid with wr_stb_o

## Operation
- Clock and reset: one clock (wb_clk_i). arst_ni is asynchronous and active-low.
- Reset values:
  - sda_oe_o=0, busy_o=0, wr_stb_o=0, wr_ptr_o=0, wr_data_o=0.
  - Pointer=0, all registers=0, FSM in IDLE.
  - Synchronizer flops reset to 1 (idle bus).
- Bus events are decoded on the synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge.
  - sda_oe_o changes only on the SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: wait for START, then go to ADDR.
- ADDR: shift in 8 bits, MSB first.
  - If bits[7:1]==SLAVE_ADDR: set busy_o and go to ADDR_ACK.
  - Otherwise: return to IDLE and ignore the bus until the next START.
- ADDR_ACK: on the falling edge after bit 8, assert sda_oe_o; release it on the next falling edge.
  - R/W=0: go to PTR.
  - R/W=1: go to RDATA. The byte at the pointer is loaded, and its MSB is driven on that same falling edge.
- PTR / PTR_ACK: receive 8 bits. pointer = byte mod NUM_REGS (upper bits discarded). ACK, then go to WDATA.
- WDATA / WDATA_ACK:
  - Receive the byte and write reg[pointer].
  - Pulse wr_stb_o in the cycle the 8th bit is sampled, with the pre-increment pointer on wr_ptr_o.
  - ACK, increment the pointer, loop to WDATA.
- RDATA: drive the byte MSB first (sda_oe_o = ~bit), changing on each falling edge.
  - After bit 8, release SDA and go to RDATA_ACK.
- RDATA_ACK: sample the master's ACK on the rising edge and increment the pointer.
  - ACK (SDA=0): load the next byte and go to RDATA.
  - NACK: release SDA, clear busy_o, go to IDLE.
- Pointer wraps NUM_REGS-1 -> 0 in both directions.
- STOP in any state: go to IDLE, sda_oe_o=0, busy_o=0. A partially received byte is discarded and not written.
- Repeated START in any state: go to ADDR, sda_oe_o=0. The pointer and the register contents are retained.
- START/STOP win over a data-bit sample when both are decoded in the same cycle.

## Timing
- Input path: 2-flop synchronizer plus one edge-detect register. Bus-edge-to-decision latency is 3 wb_clk_i cycles.
- sda_oe_o is registered. It updates 1 cycle after the decoded SCL falling edge, i.e. 4 cycles after the pad edge, well inside SCL low time at a 10x ratio.
- wr_stb_o is high for exactly 1 cycle per committed byte. The register file updates on the same edge.
- busy_o rises 1 cycle after the 8th address bit is sampled with a match. It falls 1 cycle after STOP or NACK is decoded.
- No clock stretching: SCL is never driven.

## Structure
- Package i2c_slave_pkg: the state enum, I2C_BYTE_W=8, and the ACK/NACK bit constants.
- Sub-module i2c_bus_sync:
  - Contains the SCL/SDA synchronizers and edge detection.
  - Outputs one-cycle pulses: scl_rise, scl_fall, start_det, stop_det, plus the synchronized sda.
- The top level holds the FSM, bit counter (3 bits), shift register, pointer and register array.

## Test plan
- Write 0xA0, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_stb_o at ptr 3 (0xA5) then ptr 4 (0x5A); busy_o low after STOP.
- Write 0xA0 + ptr 0x03, repeated START, 0xA1, read 2 bytes (ACK, NACK) -> SDA returns 0xA5, 0x5A; no wr_stb_o; busy_o falls after the NACK.
- Address 0xA2 (0x51) -> no ACK; sda_oe_o stays 0 through a full write transfer; busy_o stays 0.
- Write ptr 0x0F, data 0x11, 0x22 -> writes at ptr 15 then ptr 0; subsequent read from ptr 0x0F returns 0x11, 0x22.
- STOP after 4 data bits of a byte -> no wr_stb_o, pointer unchanged, FSM in IDLE.
- Assert arst_ni during RDATA with sda_oe_o=1 -> sda_oe_o=0 immediately (asynchronously); registers read back 0x00 afterwards.
